mapeamento_display_multiplexado: RTL and testbench

Parametrised, time-multiplexed N-digit seven-segment driver. It accepts 5-bit symbol codes with an even-parity bit through a valid/ready handshake and shifts them into a DIGITOS-entry display buffer. It scans the buffer one digit at a time and drives shared segment lines plus per-digit enables. It is the multi-digit successor of the single-digit code-to-segment mapper and uses the same 20-symbol table and the same parity-error glyph.

---
 rtl/mapeamento_display_multiplexado.sv | 164 ++++++++++++++++
 tb/tb_mapeamento_display_multiplexado.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mapeamento_display_multiplexado.sv
// Multiplexed N-digit seven-segment driver: shifts parity-checked symbols into a
// display buffer and scans it one digit at a time onto shared segment lines.
module mapeamento_display_multiplexado #(
  parameter int DIGITOS       = 4,
  parameter int DIV_VARREDURA = 1000,
  parameter bit ATIVO_BAIXO   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         entrada,
  input  logic               paridade,
  input  logic               valido,
  output logic               pronto,
  input  logic               limpar,
  output logic [6:0]         segmentos,
  output logic [DIGITOS-1:0] anodos,
  output logic               erro_par
);

  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam int DW = $clog2(DIV_VARREDURA);
  localparam logic [IW-1:0]      ULT_DIGITO = IW'(DIGITOS - 1);
  localparam logic [DW-1:0]      ULT_DIV    = DW'(DIV_VARREDURA - 1);
  localparam logic [6:0]         VAZIO      = 7'b1000000;
  localparam logic [6:0]         SEG_INV    = {7{ATIVO_BAIXO}};
  localparam logic [DIGITOS-1:0] AN_INV     = {DIGITOS{ATIVO_BAIXO}};

  typedef enum logic {OCIOSO, LIMPANDO} estado_t;

  estado_t             estado, prox_estado;
  logic [IW-1:0]       idx_limpa, prox_idx_limpa;
  logic                marca_vazio, inicia_limpeza;
  logic [6:0]          mem [DIGITOS];
  logic [DW-1:0]       divisor;
  logic [IW-1:0]       digito;
  logic                aceita, erro_novo;
  logic [6:0]          entrada_atual;
  logic [6:0]          padrao;
  logic [DIGITOS-1:0]  um_quente;

  assign pronto    = (estado == OCIOSO) && !limpar && !rst;
  assign aceita    = valido && pronto;
  assign erro_novo = ^{entrada, paridade};

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      idx_limpa <= '0;
    end else begin
      estado    <= prox_estado;
      idx_limpa <= prox_idx_limpa;
    end
  end

  // A repeated limpar while clearing restarts the sweep from entry 0.
  always_comb begin
    prox_estado    = estado;
    prox_idx_limpa = idx_limpa;
    marca_vazio    = 1'b0;
    inicia_limpeza = 1'b0;
    case (estado)
      OCIOSO: begin
        if (limpar) begin
          prox_estado    = LIMPANDO;
          prox_idx_limpa = '0;
          inicia_limpeza = 1'b1;
        end
      end
      LIMPANDO: begin
        if (limpar) begin
          prox_idx_limpa = '0;
        end else begin
          marca_vazio = 1'b1;
          if (idx_limpa == ULT_DIGITO) begin
            prox_estado    = OCIOSO;
            prox_idx_limpa = '0;
          end else begin
            prox_idx_limpa = idx_limpa + 1'b1;
          end
        end
      end
    endcase
  end

  // Entry layout: {vazio, errp, codigo[4:0]}; accept and clear never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIGITOS; k++) mem[k] <= VAZIO;
      erro_par <= 1'b0;
    end else begin
      if (inicia_limpeza) begin
        erro_par <= 1'b0;
      end else if (aceita) begin
        for (int k = DIGITOS - 1; k > 0; k--) mem[k] <= mem[k-1];
        mem[0] <= {1'b0, erro_novo, entrada};
        if (erro_novo) erro_par <= 1'b1;
      end
      if (marca_vazio) mem[idx_limpa][6] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= '0;
      digito  <= '0;
    end else if (divisor == ULT_DIV) begin
      divisor <= '0;
      digito  <= (digito == ULT_DIGITO) ? '0 : digito + 1'b1;
    end else begin
      divisor <= divisor + 1'b1;
    end
  end

  always_comb begin
    entrada_atual = mem[digito];
    padrao        = 7'b0000000;
    if (entrada_atual[6]) begin
      padrao = 7'b0000000;
    end else if (entrada_atual[5]) begin
      padrao = 7'b1011110;
    end else begin
      case (entrada_atual[4:0])
        5'd0:  padrao = 7'b1010100;
        5'd1:  padrao = 7'b0111011;
        5'd2:  padrao = 7'b0011100;
        5'd3:  padrao = 7'b0110111;
        5'd4:  padrao = 7'b0001111;
        5'd5:  padrao = 7'b1111110;
        5'd6:  padrao = 7'b1110111;
        5'd7:  padrao = 7'b1011011;
        5'd8:  padrao = 7'b1110011;
        5'd9:  padrao = 7'b0101010;
        5'd10: padrao = 7'b0001110;
        5'd11: padrao = 7'b1111111;
        5'd12: padrao = 7'b0111101;
        5'd13: padrao = 7'b1111001;
        5'd14: padrao = 7'b1101101;
        5'd15: padrao = 7'b1001111;
        5'd16: padrao = 7'b0110111;
        5'd17: padrao = 7'b0110011;
        5'd18: padrao = 7'b0000101;
        5'd19: padrao = 7'b1111011;
        default: padrao = 7'b0000000;
      endcase
    end
  end

  always_comb begin
    um_quente = '0;
    for (int i = 0; i < DIGITOS; i++) um_quente[i] = (digito == IW'(i));
  end

  // Outputs sample the pre-update index/buffer, so they trail them by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      segmentos <= SEG_INV;
      anodos    <= AN_INV;
    end else begin
      segmentos <= padrao ^ SEG_INV;
      anodos    <= um_quente ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_mapeamento_display_multiplexado.sv
// Bench for the multiplexed display driver: directed steps plus randomized traffic
// against a frame-level reference model (scan position from cycle arithmetic).
module tb_mapeamento_display_multiplexado;

  localparam int DIG = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, paridade = 1'b0, valido = 1'b0, limpar = 1'b0;
  logic [4:0] entrada = '0;
  logic       pronto, erro_par;
  logic [6:0] segmentos;
  logic [3:0] anodos;

  logic       rst_b = 1'b1, paridade_b = 1'b0, valido_b = 1'b0, limpar_b = 1'b0;
  logic [4:0] entrada_b = '0;
  logic       pronto_b, erro_par_b;
  logic [6:0] segmentos_b;
  logic [3:0] anodos_b;

  mapeamento_display_multiplexado #(.DIGITOS(DIG), .DIV_VARREDURA(DIV), .ATIVO_BAIXO(1'b0)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .paridade(paridade), .valido(valido),
    .pronto(pronto), .limpar(limpar), .segmentos(segmentos), .anodos(anodos), .erro_par(erro_par)
  );

  mapeamento_display_multiplexado #(.DIGITOS(DIG), .DIV_VARREDURA(DIV), .ATIVO_BAIXO(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .entrada(entrada_b), .paridade(paridade_b), .valido(valido_b),
    .pronto(pronto_b), .limpar(limpar_b), .segmentos(segmentos_b), .anodos(anodos_b), .erro_par(erro_par_b)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [6:0] glyph(input bit v, input bit e, input logic [4:0] c);
    if (v) return 7'b0000000;
    if (e) return 7'b1011110;
    case (c)
      5'd0:  return 7'b1010100;  5'd1:  return 7'b0111011;
      5'd2:  return 7'b0011100;  5'd3:  return 7'b0110111;
      5'd4:  return 7'b0001111;  5'd5:  return 7'b1111110;
      5'd6:  return 7'b1110111;  5'd7:  return 7'b1011011;
      5'd8:  return 7'b1110011;  5'd9:  return 7'b0101010;
      5'd10: return 7'b0001110;  5'd11: return 7'b1111111;
      5'd12: return 7'b0111101;  5'd13: return 7'b1111001;
      5'd14: return 7'b1101101;  5'd15: return 7'b1001111;
      5'd16: return 7'b0110111;  5'd17: return 7'b0110011;
      5'd18: return 7'b0000101;  5'd19: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: display contents as a shift list, scan digit = (cycles/DIV) mod DIG.
  bit         m_v [DIG];
  bit         m_e [DIG];
  logic [4:0] m_c [DIG];
  bit         m_clr, m_erro;
  int         m_pos, m_cyc, m_d;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_clr = 0; m_pos = 0; m_erro = 0;
      for (int i = 0; i < DIG; i++) begin m_v[i] = 1; m_e[i] = 0; m_c[i] = '0; end
      exp_seg = '0; exp_an = '0;
    end else begin
      m_d     = (m_cyc / DIV) % DIG;
      exp_an  = 4'(1 << m_d);
      exp_seg = glyph(m_v[m_d], m_e[m_d], m_c[m_d]);
      if (m_clr) begin
        if (limpar) m_pos = 0;
        else begin
          m_v[m_pos] = 1;
          m_pos++;
          if (m_pos == DIG) m_clr = 0;
        end
      end else if (limpar) begin
        m_clr = 1; m_pos = 0; m_erro = 0;
      end else if (valido) begin
        for (int k = DIG - 1; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_e[k] = m_e[k-1]; m_c[k] = m_c[k-1];
        end
        m_v[0] = 0; m_e[0] = ^{entrada, paridade}; m_c[0] = entrada;
        if (m_e[0]) m_erro = 1;
      end
      m_cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("seg", 32'(segmentos), 32'(exp_seg));
    chk("an", 32'(anodos), 32'(exp_an));
    chk("erro", 32'(erro_par), 32'(m_erro));
    chk("pronto", 32'(pronto), 32'(!rst && !m_clr && !limpar));
  endtask

  task automatic frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3);
    for (int n = 0; n < DIG * DIV; n++) begin
      tick();
      case (anodos)
        4'b0001: chk(tag, 32'(segmentos), 32'(e0));
        4'b0010: chk(tag, 32'(segmentos), 32'(e1));
        4'b0100: chk(tag, 32'(segmentos), 32'(e2));
        4'b1000: chk(tag, 32'(segmentos), 32'(e3));
        default: chk("onehot", 32'(anodos), 32'(4'b0001));
      endcase
    end
  endtask

  task automatic push(input logic [4:0] c, input logic p);
    entrada = c; paridade = p; valido = 1'b1;
    #1 chk("pronto_push", 32'(pronto), 32'd1);
    tick();
    valido = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] walk [17];
    int n;
    walk = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
             4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8, 4'd1};

    repeat (3) tick();
    chk("rst_seg", 32'(segmentos), 32'd0);
    chk("rst_an", 32'(anodos), 32'd0);
    chk("rst_seg_b", 32'(segmentos_b), 32'h7F);
    chk("rst_an_b", 32'(anodos_b), 32'hF);
    chk("rst_pronto_b", 32'(pronto_b), 32'd0);

    rst = 1'b0; rst_b = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("walk_an", 32'(anodos), 32'(walk[k]));
      chk("walk_seg", 32'(segmentos), 32'd0);
      if (k == 0) begin
        chk("b_first_an", 32'(anodos_b), 32'(4'b1110));
        chk("b_first_seg", 32'(segmentos_b), 32'h7F);
      end
    end

    push(5'd5, 1'b0); push(5'd6, 1'b0); push(5'd7, 1'b1); push(5'd0, 1'b0);
    frame("four_good", 7'b1010100, 7'b1011011, 7'b1110111, 7'b1111110);
    chk("erro_clean", 32'(erro_par), 32'd0);

    push(5'd3, 1'b1);
    frame("bad_par", 7'b1011110, 7'b1010100, 7'b1011011, 7'b1110111);
    chk("erro_set", 32'(erro_par), 32'd1);

    push(5'd25, 1'b1);
    frame("code25", 7'b0000000, 7'b1011110, 7'b1010100, 7'b1011011);
    chk("erro_sticky", 32'(erro_par), 32'd1);

    entrada = 5'd9; paridade = 1'b0; valido = 1'b1; limpar = 1'b1;
    n = 0;
    #1;
    while (pronto === 1'b0 && n < 20) begin
      n++;
      tick();
      limpar = 1'b0;
      #1;
    end
    valido = 1'b0;
    chk("pronto_low_cycles", 32'(n), 32'd5);
    frame("cleared", 7'b0, 7'b0, 7'b0, 7'b0);
    chk("erro_cleared", 32'(erro_par), 32'd0);

    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      limpar   = ($urandom_range(0, 29) == 0);
      valido   = 1'($urandom_range(0, 1));
      entrada  = 5'($urandom_range(0, 31));
      paridade = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; limpar = 1'b0; valido = 1'b0;
    tick();

    entrada_b = 5'd11; paridade_b = 1'b1; valido_b = 1'b1;
    #1 chk("b_pronto", 32'(pronto_b), 32'd1);
    tick();
    valido_b = 1'b0;
    tick();
    n = 0;
    while (anodos_b !== 4'b1110 && n < 40) begin
      tick();
      n++;
    end
    chk("b_scan_reached", 32'(n < 40), 32'd1);
    chk("b_seg11", 32'(segmentos_b), 32'd0);
    chk("b_an_digit0", 32'(anodos_b), 32'(4'b1110));
    chk("b_erro", 32'(erro_par_b), 32'd0);

    limpar_b = 1'b1;
    tick();
    limpar_b = 1'b0;
    tick();
    chk("b_midclear_pronto", 32'(pronto_b), 32'd0);
    rst_b = 1'b1;
    tick();
    chk("b_rst_an", 32'(anodos_b), 32'hF);
    chk("b_rst_seg", 32'(segmentos_b), 32'h7F);
    chk("b_rst_erro", 32'(erro_par_b), 32'd0);
    rst_b = 1'b0;
    tick();
    chk("b_after_rst_an", 32'(anodos_b), 32'(4'b1110));
    chk("b_after_rst_pronto", 32'(pronto_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
